axi_lite_to_apb_bridge: RTL and testbench
=========================================

AXI_LITE_TO_APB_BRIDGE -- requirements
Module: axi_lite_to_apb_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning AXI and APB address width.
REQ-002 SHALL have parameter DATA_W, default 32 (only 32 supported), meaning data width; strobe width is DATA_W/8.
REQ-003 SHALL have: axi_clk  in  1  single clock for AXI-Lite and APB sides; reset is asynchronous and active-high.
REQ-004 SHALL have: sys_areset  in  1  asynchronous active-high reset.
REQ-005 SHALL have AXI-Lite slave write ports: s_awaddr in ADDR_W, s_awvalid in 1, s_awready out 1, s_wdata in DATA_W, s_wstrb in DATA_W/8, s_wvalid in 1, s_wready out 1, s_bresp out 2, s_bvalid out 1, s_bready in 1.
REQ-006 SHALL have AXI-Lite slave read ports: s_araddr in ADDR_W, s_arvalid in 1, s_arready out 1, s_rdata out DATA_W, s_rresp out 2, s_rvalid out 1, s_rready in 1.
REQ-007 SHALL have APB master ports: m_psel out 1, m_penable out 1, m_pwrite out 1, m_paddr out ADDR_W, m_pwdata out DATA_W, m_pstrb out DATA_W/8, m_pready in 1, m_prdata in DATA_W, m_pslverr in 1.

Function
REQ-008 SHALL hold AW and W in independent one-entry holding registers; s_awready=1 while the AW register is empty; s_wready=1 while the W register is empty; either order or the same cycle is accepted.
REQ-009 SHALL hold AR in a one-entry register; s_arready=1 while it is empty and no read response is pending.
REQ-010 SHALL use FSM states IDLE, SETUP, ACCESS, RESP.
REQ-011 IDLE -> SETUP when a write (AW and W both held) or a read (AR held) is pending.
REQ-012 When both a write and a read are pending in IDLE, the bridge SHALL grant the type not served last; after reset, read wins.
REQ-013 SETUP: m_psel=1, m_penable=0, with address, pwrite, pwdata and pstrb driven from the held request; the FSM SHALL go to ACCESS next cycle.
REQ-014 ACCESS: m_psel=1, m_penable=1; the FSM SHALL stay while m_pready=0 (no timeout) and go to RESP on m_pready=1.
REQ-015 On the m_pready=1 cycle, the bridge SHALL capture m_prdata (read) and m_pslverr, and free the consumed holding registers.
REQ-016 RESP: assert s_bvalid (write) or s_rvalid (read), resp=2'b10 if pslverr else 2'b00; hold until s_bready/s_rready, then return to IDLE.
REQ-017 APB outputs SHALL be stable SETUP through ACCESS; m_pstrb=0 and m_pwdata=0 for reads; psel=penable=0 in IDLE and RESP.
REQ-018 Minimum latency: handshake in cycle 0, SETUP cycle 1, ACCESS cycle 2 with pready=1, response valid cycle 3.
REQ-019 At most one APB transfer SHALL be outstanding; new AW/W/AR may be accepted into empty holding registers during an active transfer.

Reset
REQ-020 sys_areset SHALL asynchronously force: FSM IDLE, holding registers empty, s_awready=s_wready=s_arready=0 while asserted, s_bvalid=s_rvalid=0, s_bresp=s_rresp=0, s_rdata=0, m_psel=m_penable=m_pwrite=0, m_paddr=m_pwdata=m_pstrb=0, last-served=write.
REQ-021 Reset mid-transfer SHALL abort without a response; the first cycle after deassertion is IDLE with readies=1.

Structure
REQ-022 A shared package axi_lite_apb_pkg SHALL hold the FSM state enum, the resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, and the default widths.
REQ-023 The three holding registers SHALL be one sub-module, axi_lite_req_latch (valid/ready capture of a single beat), instantiated three times.

Verification
REQ-024 Write addr 0x10, data 0xDEADBEEF, strb 0xF, AW and W in the same cycle, pready=1 -> SETUP cycle 1, ACCESS cycle 2, bvalid cycle 3, bresp=0.
REQ-025 Read addr 0x20, pready low for 3 ACCESS cycles, prdata=0x12345678 -> rvalid with rdata=0x12345678; APB signals stable throughout.
REQ-026 W five cycles before AW -> no APB activity until AW is accepted, then a normal write.
REQ-027 AR and AW+W pending together after reset -> read first, then write; repeat -> alternation.
REQ-028 pslverr=1 on write and on read -> bresp=2'b10 and rresp=2'b10; bready held low for 4 cycles -> bvalid held, no new APB transfer.
REQ-029 Assert sys_areset during ACCESS -> all outputs at reset values immediately; no b/r response after release.

Source files
------------

// File: rtl/axi_lite_apb_pkg.sv
// Shared types and constants for the AXI-Lite to APB bridge.
// Holds FSM states, response codes and default widths.
package axi_lite_apb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/axi_lite_req_latch.sv
// One-entry valid/ready holding register for a single AXI-Lite beat.
// Presents the incoming beat as a bypass so the FSM can start the same cycle.
module axi_lite_req_latch
  import axi_lite_apb_pkg::*;
#(
  parameter int W = DEF_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  output logic         ready,
  input  logic [W-1:0] d,
  input  logic         stall,
  input  logic         pop,
  output logic         avail,
  output logic [W-1:0] data
);

  logic         full;
  logic [W-1:0] hold;

  assign ready = !full && !stall && !rst;
  assign avail = full || (valid && ready);
  assign data  = full ? hold : d;

  // pop only happens while full, so it never collides with a capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      hold <= '0;
    end else begin
      if (pop) begin
        full <= 1'b0;
      end
      if (valid && ready) begin
        full <= 1'b1;
        hold <= d;
      end
    end
  end

endmodule

// File: rtl/axi_lite_to_apb_bridge.sv
// AXI-Lite slave to APB master bridge, one APB transfer at a time.
// Reads and writes alternate when both are pending; read wins after reset.
module axi_lite_to_apb_bridge
  import axi_lite_apb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                axi_clk,
  input  logic                sys_areset,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [ADDR_W-1:0]   m_paddr,
  output logic [DATA_W-1:0]   m_pwdata,
  output logic [DATA_W/8-1:0] m_pstrb,
  input  logic                m_pready,
  input  logic [DATA_W-1:0]   m_prdata,
  input  logic                m_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WB_W   = DATA_W + STRB_W;

  apb_state_e state;
  logic       last_wr;
  logic       cur_wr;

  logic              aw_av;
  logic              w_av;
  logic              ar_av;
  logic [ADDR_W-1:0] aw_addr;
  logic [ADDR_W-1:0] ar_addr;
  logic [WB_W-1:0]   w_beat;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;

  logic done;
  logic pop_wr;
  logic pop_rd;
  logic wr_pend;
  logic rd_pend;
  logic grant_rd;
  logic grant_wr;

  assign w_data = w_beat[DATA_W-1:0];
  assign w_strb = w_beat[WB_W-1:DATA_W];

  assign done   = (state == ACCESS) && m_pready;
  assign pop_wr = done && cur_wr;
  assign pop_rd = done && !cur_wr;

  assign wr_pend  = aw_av && w_av;
  assign rd_pend  = ar_av;
  assign grant_rd = rd_pend && (!wr_pend || last_wr);
  assign grant_wr = wr_pend && !grant_rd;

  axi_lite_req_latch #(.W(ADDR_W)) u_aw (
    .clk   (axi_clk),
    .rst   (sys_areset),
    .valid (s_awvalid),
    .ready (s_awready),
    .d     (s_awaddr),
    .stall (1'b0),
    .pop   (pop_wr),
    .avail (aw_av),
    .data  (aw_addr)
  );

  axi_lite_req_latch #(.W(WB_W)) u_w (
    .clk   (axi_clk),
    .rst   (sys_areset),
    .valid (s_wvalid),
    .ready (s_wready),
    .d     ({s_wstrb, s_wdata}),
    .stall (1'b0),
    .pop   (pop_wr),
    .avail (w_av),
    .data  (w_beat)
  );

  // a pending read response blocks new AR beats
  axi_lite_req_latch #(.W(ADDR_W)) u_ar (
    .clk   (axi_clk),
    .rst   (sys_areset),
    .valid (s_arvalid),
    .ready (s_arready),
    .d     (s_araddr),
    .stall (s_rvalid),
    .pop   (pop_rd),
    .avail (ar_av),
    .data  (ar_addr)
  );

  always_ff @(posedge axi_clk or posedge sys_areset) begin
    if (sys_areset) begin
      state     <= IDLE;
      last_wr   <= 1'b1;
      cur_wr    <= 1'b0;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      m_pstrb   <= '0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_rvalid  <= 1'b0;
      s_rresp   <= RESP_OKAY;
      s_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_rd || grant_wr) begin
            state     <= SETUP;
            cur_wr    <= grant_wr;
            last_wr   <= grant_wr;
            m_psel    <= 1'b1;
            m_penable <= 1'b0;
            m_pwrite  <= grant_wr;
            m_paddr   <= grant_wr ? aw_addr : ar_addr;
            m_pwdata  <= grant_wr ? w_data : '0;
            m_pstrb   <= grant_wr ? w_strb : '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          m_penable <= 1'b1;
        end
        ACCESS: begin
          if (m_pready) begin
            state     <= RESP;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            if (cur_wr) begin
              s_bvalid <= 1'b1;
              s_bresp  <= m_pslverr ? RESP_SLVERR : RESP_OKAY;
            end else begin
              s_rvalid <= 1'b1;
              s_rdata  <= m_prdata;
              s_rresp  <= m_pslverr ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        RESP: begin
          if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
            state    <= IDLE;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_to_apb_bridge.sv
// Directed bench for the AXI-Lite to APB bridge.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_lite_to_apb_bridge;

  logic        axi_clk;
  logic        sys_areset;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic        m_pready;
  logic [31:0] m_prdata;
  logic        m_pslverr;

  int checks = 0;
  int errors = 0;

  axi_lite_to_apb_bridge dut (
    .axi_clk    (axi_clk),
    .sys_areset (sys_areset),
    .s_awaddr   (s_awaddr),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_bresp    (s_bresp),
    .s_bvalid   (s_bvalid),
    .s_bready   (s_bready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .m_psel     (m_psel),
    .m_penable  (m_penable),
    .m_pwrite   (m_pwrite),
    .m_paddr    (m_paddr),
    .m_pwdata   (m_pwdata),
    .m_pstrb    (m_pstrb),
    .m_pready   (m_pready),
    .m_prdata   (m_prdata),
    .m_pslverr  (m_pslverr)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_setup(input int max);
    int n;
    n = 0;
    while (!(m_psel === 1'b1 && m_penable === 1'b0) && n < max) begin
      @(negedge axi_clk);
      n++;
    end
    chk("setup_wait", 64'(n < max), 64'd1);
  endtask

  task automatic drive_wr(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
    s_awaddr  = a;
    s_awvalid = 1'b1;
    s_wdata   = d;
    s_wstrb   = s;
    s_wvalid  = 1'b1;
  endtask

  task automatic ack_b();
    s_bready = 1'b1;
    @(negedge axi_clk);
    s_bready = 1'b0;
  endtask

  task automatic ack_r();
    s_rready = 1'b1;
    @(negedge axi_clk);
    s_rready = 1'b0;
  endtask

  task automatic pulse_reset();
    sys_areset = 1'b1;
    @(negedge axi_clk);
    sys_areset = 1'b0;
    @(negedge axi_clk);
  endtask

  initial begin
    sys_areset = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    m_pready = 1'b1; m_prdata = '0; m_pslverr = 1'b0;

    // reset state
    repeat (2) @(negedge axi_clk);
    chk("rst_awready", s_awready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_psel", m_psel, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_paddr", m_paddr, 0);
    sys_areset = 1'b0;
    @(negedge axi_clk);
    chk("idle_awready", s_awready, 1);
    chk("idle_wready", s_wready, 1);
    chk("idle_arready", s_arready, 1);

    // minimum-latency write, AW and W together
    drive_wr(32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge axi_clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("w1_setup_psel", m_psel, 1);
    chk("w1_setup_pen", m_penable, 0);
    chk("w1_pwrite", m_pwrite, 1);
    chk("w1_paddr", m_paddr, 32'h10);
    chk("w1_pwdata", m_pwdata, 32'hDEADBEEF);
    chk("w1_pstrb", m_pstrb, 4'hF);
    @(negedge axi_clk);
    chk("w1_access_pen", m_penable, 1);
    chk("w1_access_psel", m_psel, 1);
    @(negedge axi_clk);
    chk("w1_bvalid", s_bvalid, 1);
    chk("w1_bresp", s_bresp, 2'b00);
    chk("w1_psel_off", m_psel, 0);
    ack_b();
    chk("w1_bvalid_clr", s_bvalid, 0);

    // read with three wait states
    m_pready = 1'b0;
    s_araddr = 32'h20; s_arvalid = 1'b1;
    @(negedge axi_clk);
    s_arvalid = 1'b0;
    chk("r1_setup_pen", m_penable, 0);
    chk("r1_pwrite", m_pwrite, 0);
    chk("r1_paddr", m_paddr, 32'h20);
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_clk);
      chk("r1_wait_psel", m_psel, 1);
      chk("r1_wait_pen", m_penable, 1);
      chk("r1_wait_paddr", m_paddr, 32'h20);
      chk("r1_wait_pstrb", m_pstrb, 0);
      chk("r1_wait_pwdata", m_pwdata, 0);
      chk("r1_wait_rvalid", s_rvalid, 0);
    end
    @(negedge axi_clk);
    chk("r1_still_access", m_penable, 1);
    m_pready = 1'b1;
    m_prdata = 32'h12345678;
    @(negedge axi_clk);
    chk("r1_rvalid", s_rvalid, 1);
    chk("r1_rdata", s_rdata, 32'h12345678);
    chk("r1_rresp", s_rresp, 2'b00);
    chk("r1_arready_blk", s_arready, 0);
    ack_r();
    chk("r1_rvalid_clr", s_rvalid, 0);

    // W arrives five cycles before AW
    s_wdata = 32'hCAFEF00D; s_wstrb = 4'h3; s_wvalid = 1'b1;
    @(negedge axi_clk);
    s_wvalid = 1'b0;
    chk("w2_wready_full", s_wready, 0);
    for (int i = 0; i < 5; i++) begin
      chk("w2_no_psel", m_psel, 0);
      @(negedge axi_clk);
    end
    chk("w2_awready", s_awready, 1);
    s_awaddr = 32'h30; s_awvalid = 1'b1;
    @(negedge axi_clk);
    s_awvalid = 1'b0;
    chk("w2_setup_psel", m_psel, 1);
    chk("w2_paddr", m_paddr, 32'h30);
    chk("w2_pwdata", m_pwdata, 32'hCAFEF00D);
    chk("w2_pstrb", m_pstrb, 4'h3);
    @(negedge axi_clk);
    @(negedge axi_clk);
    chk("w2_bvalid", s_bvalid, 1);
    chk("w2_wready_free", s_wready, 1);
    ack_b();

    // arbitration after reset: read first, then write, twice
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      s_araddr = 32'h40 + 32'(k * 4); s_arvalid = 1'b1;
      drive_wr(32'h50 + 32'(k * 4), 32'h11112222, 4'hF);
      @(negedge axi_clk);
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      chk("arb_first_rd", m_pwrite, 0);
      chk("arb_first_addr", m_paddr, 32'h40 + 32'(k * 4));
      @(negedge axi_clk);
      @(negedge axi_clk);
      chk("arb_rvalid", s_rvalid, 1);
      chk("arb_no_bvalid", s_bvalid, 0);
      ack_r();
      wait_setup(4);
      chk("arb_then_wr", m_pwrite, 1);
      chk("arb_wr_addr", m_paddr, 32'h50 + 32'(k * 4));
      @(negedge axi_clk);
      @(negedge axi_clk);
      chk("arb_bvalid", s_bvalid, 1);
      ack_b();
    end

    // after a lone read, a simultaneous pair grants the write first
    pulse_reset();
    s_araddr = 32'h48; s_arvalid = 1'b1;
    @(negedge axi_clk);
    s_arvalid = 1'b0;
    @(negedge axi_clk);
    @(negedge axi_clk);
    ack_r();
    s_araddr = 32'h4C; s_arvalid = 1'b1;
    drive_wr(32'h58, 32'h0A0B0C0D, 4'h5);
    @(negedge axi_clk);
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("fair_wr_first", m_pwrite, 1);
    chk("fair_wr_addr", m_paddr, 32'h58);
    @(negedge axi_clk);
    @(negedge axi_clk);
    ack_b();
    wait_setup(4);
    chk("fair_rd_next", m_pwrite, 0);
    chk("fair_rd_addr", m_paddr, 32'h4C);
    @(negedge axi_clk);
    @(negedge axi_clk);
    ack_r();

    // slave error on write with stalled bready, then on read
    m_pslverr = 1'b1;
    drive_wr(32'h60, 32'h1, 4'h1);
    @(negedge axi_clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge axi_clk);
    @(negedge axi_clk);
    chk("err_bvalid", s_bvalid, 1);
    chk("err_bresp", s_bresp, 2'b10);
    s_araddr = 32'h64; s_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge axi_clk);
      s_arvalid = 1'b0;
      chk("err_bvalid_hold", s_bvalid, 1);
      chk("err_no_apb", m_psel, 0);
    end
    ack_b();
    chk("err_bvalid_clr", s_bvalid, 0);
    wait_setup(4);
    chk("err_rd_addr", m_paddr, 32'h64);
    chk("err_rd_pwrite", m_pwrite, 0);
    @(negedge axi_clk);
    @(negedge axi_clk);
    chk("err_rvalid", s_rvalid, 1);
    chk("err_rresp", s_rresp, 2'b10);
    ack_r();
    m_pslverr = 1'b0;

    // reset during ACCESS aborts without a response
    m_pready = 1'b0;
    drive_wr(32'h70, 32'h55AA55AA, 4'hF);
    @(negedge axi_clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge axi_clk);
    chk("abort_in_access", m_penable, 1);
    #2 sys_areset = 1'b1;
    #1;
    chk("abort_psel", m_psel, 0);
    chk("abort_penable", m_penable, 0);
    chk("abort_pwrite", m_pwrite, 0);
    chk("abort_paddr", m_paddr, 0);
    chk("abort_pwdata", m_pwdata, 0);
    chk("abort_pstrb", m_pstrb, 0);
    chk("abort_awready", s_awready, 0);
    chk("abort_wready", s_wready, 0);
    @(negedge axi_clk);
    m_pready = 1'b1;
    sys_areset = 1'b0;
    @(negedge axi_clk);
    chk("rel_awready", s_awready, 1);
    chk("rel_wready", s_wready, 1);
    chk("rel_arready", s_arready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("rel_no_bvalid", s_bvalid, 0);
      chk("rel_no_rvalid", s_rvalid, 0);
      chk("rel_no_psel", m_psel, 0);
      @(negedge axi_clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
